// File: rtl/time_of_day_counter_if.sv
// Bundles the tick/run/set controls and the BCD time-of-day outputs
// exchanged between the alarm-clock controller and the time-of-day counter.
interface time_of_day_counter_if;
    logic       tick;
    logic       run;
    logic       inc_min;
    logic       inc_hr;
    logic [1:0] hr_tens;
    logic [3:0] hr_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       sec_pulse;
    logic       day_pulse;

    modport master (
        output tick, run, inc_min, inc_hr,
        input  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
        input  sec_pulse, day_pulse
    );

    modport slave (
        input  tick, run, inc_min, inc_hr,
        output hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
        output sec_pulse, day_pulse
    );
endinterface

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter: divides the upstream tick to seconds,
// supports manual minute/hour setting and emits second/day strobes.
module time_of_day_counter #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    time_of_day_counter_if.slave  bus
);

    localparam int             PW        = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]  PCNT_LAST = PW'(TICKS_PER_SEC - 1);

    function automatic logic [3:0] bcd_ones_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [2:0] bcd_tens6_inc(input logic [2:0] d);
        return (d == 3'd5) ? 3'd0 : d + 3'd1;
    endfunction

    logic [PW-1:0] r_pcnt;
    logic [3:0]    r_sec_ones;
    logic [2:0]    r_sec_tens;
    logic [3:0]    r_min_ones;
    logic [2:0]    r_min_tens;
    logic [3:0]    r_hr_ones;
    logic [1:0]    r_hr_tens;
    logic          r_sec_pulse;
    logic          r_day_pulse;

    logic [PW-1:0] w_pcnt_nxt;
    logic [3:0]    w_sec_ones_nxt;
    logic [2:0]    w_sec_tens_nxt;
    logic [3:0]    w_min_ones_nxt;
    logic [2:0]    w_min_tens_nxt;
    logic [3:0]    w_hr_ones_nxt;
    logic [1:0]    w_hr_tens_nxt;
    logic          w_tick_acc;
    logic          w_sec_carry;
    logic          w_sec_at_max;
    logic          w_min_at_max;
    logic          w_hr_at_max;
    logic          w_min_carry;
    logic          w_hr_carry;
    logic          w_day_wrap;
    logic          w_min_adv;
    logic          w_hr_adv;

    assign w_tick_acc   = bus.run & bus.tick;
    assign w_sec_carry  = w_tick_acc & (r_pcnt == PCNT_LAST);
    assign w_sec_at_max = (r_sec_tens == 3'd5) && (r_sec_ones == 4'd9);
    assign w_min_at_max = (r_min_tens == 3'd5) && (r_min_ones == 4'd9);
    assign w_hr_at_max  = (r_hr_tens == 2'd2) && (r_hr_ones == 4'd3);

    // A manual request owns its field: it absorbs any carry arriving into that
    // field in the same cycle, so the field advances once and nothing ripples on.
    assign w_min_carry  = w_sec_carry & w_sec_at_max;
    assign w_hr_carry   = w_min_carry & ~bus.inc_min & w_min_at_max;
    assign w_day_wrap   = w_hr_carry & ~bus.inc_hr & w_hr_at_max;
    assign w_min_adv    = bus.inc_min | w_min_carry;
    assign w_hr_adv     = bus.inc_hr | w_hr_carry;

    // Prescaler next state: counts accepted ticks, holds while frozen.
    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (w_sec_carry) begin
            w_pcnt_nxt = '0;
        end else if (w_tick_acc) begin
            w_pcnt_nxt = r_pcnt + PW'(1);
        end else begin
            w_pcnt_nxt = r_pcnt;
        end
    end

    // Seconds and minutes next state using the 9/5 BCD digit rules.
    always_comb begin
        w_sec_ones_nxt = r_sec_ones;
        w_sec_tens_nxt = r_sec_tens;
        w_min_ones_nxt = r_min_ones;
        w_min_tens_nxt = r_min_tens;
        if (w_sec_carry) begin
            w_sec_ones_nxt = bcd_ones_inc(r_sec_ones);
            w_sec_tens_nxt = (r_sec_ones == 4'd9) ? bcd_tens6_inc(r_sec_tens) : r_sec_tens;
        end else begin
            w_sec_ones_nxt = r_sec_ones;
            w_sec_tens_nxt = r_sec_tens;
        end
        if (w_min_adv) begin
            w_min_ones_nxt = bcd_ones_inc(r_min_ones);
            w_min_tens_nxt = (r_min_ones == 4'd9) ? bcd_tens6_inc(r_min_tens) : r_min_tens;
        end else begin
            w_min_ones_nxt = r_min_ones;
            w_min_tens_nxt = r_min_tens;
        end
    end

    // Hours next state: 24-hour wrap at 23, tens only carries below 2.
    always_comb begin
        w_hr_ones_nxt = r_hr_ones;
        w_hr_tens_nxt = r_hr_tens;
        if (!w_hr_adv) begin
            w_hr_ones_nxt = r_hr_ones;
            w_hr_tens_nxt = r_hr_tens;
        end else if (w_hr_at_max) begin
            w_hr_ones_nxt = 4'd0;
            w_hr_tens_nxt = 2'd0;
        end else if (r_hr_ones == 4'd9) begin
            w_hr_ones_nxt = 4'd0;
            w_hr_tens_nxt = r_hr_tens + 2'd1;
        end else begin
            w_hr_ones_nxt = r_hr_ones + 4'd1;
            w_hr_tens_nxt = r_hr_tens;
        end
    end

    // State and strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt      <= '0;
            r_sec_ones  <= 4'd0;
            r_sec_tens  <= 3'd0;
            r_min_ones  <= 4'd0;
            r_min_tens  <= 3'd0;
            r_hr_ones   <= 4'd0;
            r_hr_tens   <= 2'd0;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
        end else begin
            r_pcnt      <= w_pcnt_nxt;
            r_sec_ones  <= w_sec_ones_nxt;
            r_sec_tens  <= w_sec_tens_nxt;
            r_min_ones  <= w_min_ones_nxt;
            r_min_tens  <= w_min_tens_nxt;
            r_hr_ones   <= w_hr_ones_nxt;
            r_hr_tens   <= w_hr_tens_nxt;
            r_sec_pulse <= w_sec_carry;
            r_day_pulse <= w_day_wrap;
        end
    end

    assign bus.hr_tens   = r_hr_tens;
    assign bus.hr_ones   = r_hr_ones;
    assign bus.min_tens  = r_min_tens;
    assign bus.min_ones  = r_min_ones;
    assign bus.sec_tens  = r_sec_tens;
    assign bus.sec_ones  = r_sec_ones;
    assign bus.sec_pulse = r_sec_pulse;
    assign bus.day_pulse = r_day_pulse;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with four ticks per second; times are
// compared as packed hex HHMMSS so hand-computed values read naturally.
module tb_time_of_day_counter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    time_of_day_counter_if bus ();

    time_of_day_counter #(.TICKS_PER_SEC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [23:0] exp);
        chk(tag, {2'b00, bus.hr_tens, bus.hr_ones, 1'b0, bus.min_tens, bus.min_ones,
                  1'b0, bus.sec_tens, bus.sec_ones}, exp);
    endtask

    task automatic chk_strobes(input string tag, input logic sp, input logic dp);
        chk(tag, {22'd0, bus.sec_pulse, bus.day_pulse}, {22'd0, sp, dp});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic t, input logic m, input logic h);
        bus.tick    = t;
        bus.inc_min = m;
        bus.inc_hr  = h;
        @(posedge clk);
        #1;
        bus.tick    = 1'b0;
        bus.inc_min = 1'b0;
        bus.inc_hr  = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            drive(1'b1, 1'b0, 1'b0);
            idle(1);
        end
    endtask

    task automatic inc_hours(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic inc_mins(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bus.tick    = 1'b0;
        bus.run     = 1'b1;
        bus.inc_min = 1'b0;
        bus.inc_hr  = 1'b0;
        #12;
        chk_time("reset_time", 24'h000000);
        chk_strobes("reset_strobes", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Second boundary: ticks three cycles apart, only the fourth is visible.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk_time("pre_tick_time", 24'h000000);
            chk_strobes("pre_tick_strobes", 1'b0, 1'b0);
            idle(2);
        end
        drive(1'b1, 1'b0, 1'b0);
        chk_time("first_second", 24'h000001);
        chk_strobes("first_sec_pulse", 1'b1, 1'b0);
        idle(1);
        chk_strobes("sec_pulse_one_cycle", 1'b0, 1'b0);

        // Preset 12:34:56 then leave the prescaler at 2.
        inc_hours(12);
        inc_mins(34);
        chk_time("preset_1234", 24'h123401);
        ticks(55 * 4);
        chk_time("preset_123456", 24'h123456);
        ticks(2);

        // Freeze keeps the partial count; exactly two more ticks finish the second.
        bus.run = 1'b0;
        ticks(10);
        chk_time("frozen_time", 24'h123456);
        bus.run = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk_time("resume_tick3", 24'h123456);
        chk_strobes("resume_tick3_strobes", 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 1'b0);
        chk_time("resume_tick4", 24'h123457);
        chk_strobes("resume_sec_pulse", 1'b1, 1'b0);
        idle(1);

        // Asynchronous reset mid-cycle with a partial prescaler count.
        ticks(2);
        #3;
        reset = 1'b1;
        #1;
        chk_time("async_reset_time", 24'h000000);
        chk_strobes("async_reset_strobes", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_strobes("reset_held_strobes", 1'b0, 1'b0);
        reset = 1'b0;
        ticks(3);
        chk_time("post_reset_3ticks", 24'h000000);
        drive(1'b1, 1'b0, 1'b0);
        chk_time("post_reset_4ticks", 24'h000001);
        idle(1);

        // Manual minute wrap never carries into hours.
        inc_hours(10);
        inc_mins(59);
        chk_time("set_1059", 24'h105901);
        drive(1'b0, 1'b1, 1'b0);
        chk_time("inc_min_wrap", 24'h100001);

        // inc_min colliding with a minute carry advances minutes once.
        inc_hours(19);
        chk_time("set_05", 24'h050001);
        inc_mins(9);
        ticks(58 * 4);
        chk_time("set_050959", 24'h050959);
        ticks(3);
        drive(1'b1, 1'b1, 1'b0);
        chk_time("collide_min", 24'h051000);
        chk_strobes("collide_min_strobes", 1'b1, 1'b0);
        idle(1);

        // inc_hr colliding with an hour carry advances hours once.
        inc_mins(49);
        ticks(59 * 4);
        chk_time("set_055959", 24'h055959);
        ticks(3);
        drive(1'b1, 1'b0, 1'b1);
        chk_time("collide_hr", 24'h060000);
        chk_strobes("collide_hr_strobes", 1'b1, 1'b0);
        idle(1);

        // Manual hour wrap 23 -> 00 without a day strobe.
        inc_hours(17);
        chk_time("set_23", 24'h230000);
        drive(1'b0, 1'b0, 1'b1);
        chk_time("inc_hr_wrap", 24'h000000);
        chk_strobes("inc_hr_wrap_strobes", 1'b0, 1'b0);

        // Full day rollover from 23:59:59.
        inc_hours(23);
        inc_mins(59);
        ticks(59 * 4);
        chk_time("set_235959", 24'h235959);
        ticks(3);
        drive(1'b1, 1'b0, 1'b0);
        chk_time("day_rollover", 24'h000000);
        chk_strobes("day_rollover_strobes", 1'b1, 1'b1);
        idle(1);
        chk_strobes("day_strobes_one_cycle", 1'b0, 1'b0);
        chk_time("after_rollover", 24'h000000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Time-of-day counter for the alarm clock. It sits directly downstream of the periodic tick generator and consumes its one-cycle `tick` pulse, nominally 1 kHz. It divides that pulse down to seconds and keeps hours, minutes and seconds in BCD for 24-hour time. It also supports manual minute/hour setting and emits single-cycle second-boundary and day-rollover strobes for the display and alarm logic.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 1000: number of `tick` pulses per second. Legal range is 2 to 2^20. The prescaler width is $clog2(TICKS_PER_SEC).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle pulse from the upstream tick generator. Never asserted on consecutive cycles.
- `run`  in  1  1 = advance time on ticks; 0 = freeze prescaler and time.
- `inc_min`  in  1  one-cycle request: minutes +1.
- `inc_hr`  in  1  one-cycle request: hours +1.
- `hr_tens`  out  2  hours tens digit, 0–2.
- `hr_ones`  out  4  hours ones digit, 0–9.
- `min_tens`  out  3  minutes tens digit, 0–5.
- `min_ones`  out  4  minutes ones digit, 0–9.
- `sec_tens`  out  3  seconds tens digit, 0–5.
- `sec_ones`  out  4  seconds ones digit, 0–9.
- `sec_pulse`  out  1  one-cycle strobe; the seconds value just advanced.
- `day_pulse`  out  1  one-cycle strobe; time just wrapped 23:59:59 → 00:00:00.

## Operation
- **Prescaler** `pcnt` (0..TICKS_PER_SEC-1):
  - When `run` and `tick` are both high, `pcnt` increments.
  - When `pcnt == TICKS_PER_SEC-1` and a tick is accepted, `pcnt` returns to 0 and a second carry is generated.
  - When `run` is 0, ticks are ignored and `pcnt` holds. It does not clear.
- **Carry chain** (one second carry):
  - `sec_ones` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 carries a minute carry.
  - Minutes use the same 9/5 digit rules and produce an hour carry on 59→00.
  - Hours are 24-hour: on 23→00 the next state is `hr_tens` = 0, `hr_ones` = 0, and `day_pulse` asserts. `hr_ones` wraps 9→0 with `hr_tens`+1 only when `hr_tens` < 2.
- **Manual set:**
  - `inc_min` advances minutes by exactly 1, wrapping 59→00. It never carries into hours.
  - `inc_hr` advances hours by exactly 1, wrapping 23→00. It never asserts `day_pulse`.
  - Both inputs act regardless of `run`. Seconds and prescaler are unaffected.
- **Simultaneous events** (same cycle):
  - `inc_min` with a minute carry from seconds: minutes advance by 1 total, not 2. Seconds still wrap normally. Any hour carry is suppressed, because `inc_min` governs the minute field.
  - `inc_hr` with an hour carry from minutes: hours advance by 1 total. `day_pulse` is not asserted.
  - `inc_min` and `inc_hr` together: both fields advance by 1 independently.
- Digits are stored and updated in BCD only, with no binary-to-BCD conversion. Illegal digit codes are unreachable from reset.

## Timing
- Reset, asynchronous and immediate: all digits 0 (00:00:00), `pcnt` = 0, `sec_pulse` = 0, `day_pulse` = 0.
- Reset released mid-operation: counting resumes from 00:00:00 with the first accepted tick after release. A tick in the release cycle is accepted if it is sampled on that edge.
- **Latency:** one cycle.
  - The edge that samples the completing tick updates the digits.
  - `sec_pulse` and `day_pulse` are registered and are high during the first cycle in which the new time is visible.
  - Both strobes are low on every other cycle.
- `inc_min` / `inc_hr` take effect on the sampling edge; the new value is visible the next cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `reset` mid-count at 12:34:56 → outputs read 00:00:00 and both strobes stay 0 while `reset` is high, with no clock edge required.
- **Second boundary:** TICKS_PER_SEC=4, `run`=1, 4 ticks spaced 3 cycles apart → `sec_ones` 0→1 on the edge after the 4th tick; `sec_pulse` high exactly 1 cycle; ticks 1–3 change nothing visible.
- **Day rollover:** preset via `inc_hr`/`inc_min` plus ticks to 23:59:59, then complete 1 second → 00:00:00, `sec_pulse` and `day_pulse` both high the same single cycle.
- **Freeze:** `run`=0 with 10 ticks → time and `pcnt` unchanged. `run`=1 resumes from the same `pcnt`; the second completes after exactly the remaining ticks.
- **Set wrap:** at 10:59:xx, pulse `inc_min` → 10:00:xx with hours unchanged. At 23:mm, pulse `inc_hr` → 00:mm, `day_pulse` stays 0.
- **Collision:** at 05:09:59, with `inc_min` in the same cycle as the completing tick → 05:10:00, not 05:11:00. At 05:59:59, with `inc_hr` and the completing tick together → 06:00:00, `day_pulse` = 0.
